// File: rtl/parammod_pkg.sv
// Shared definitions for the cnt_bits family: counted-bit polarity and the
// frame accumulator's FSM state encoding.
package parammod_pkg;
  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic {CBA_RUN, CBA_HOLD} cba_state_t;
endpackage

// File: rtl/cnt_bits.sv
// Combinational population count of ACT-valued bits in an IN-bit slice.
module cnt_bits
  import parammod_pkg::*;
#(
  parameter int   IN  = 5,
  parameter logic ACT = HIGH,
  localparam int  OW  = $clog2(IN) + 1
) (
  input  logic [IN-1:0] in,
  output logic [OW-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < IN; i++)
      if (in[i] == ACT) out = out + OW'(1);
  end

endmodule

// File: rtl/cnt_bits_acc.sv
// Frame-level popcount accumulator: sums cnt_bits over slices until in_last
// or FRAME slices, then holds the total on a valid/ready output.
module cnt_bits_acc
  import parammod_pkg::*;
#(
  parameter int   IN    = 5,
  parameter logic ACT   = HIGH,
  parameter int   FRAME = 4,
  parameter int   SW    = $clog2(FRAME + 1),
  parameter int   CW    = $clog2(IN * FRAME + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IN-1:0] in,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out,
  output logic [SW-1:0] out_nslice,
  output logic          out_ovf
);

  localparam int PW = $clog2(IN) + 1;

  cba_state_t    state, state_nxt;
  logic [CW-1:0] acc;
  logic [SW-1:0] nslice;
  logic          ovf;
  logic [PW-1:0] cnt;
  logic          accept, close;

  cnt_bits #(.IN(IN), .ACT(ACT)) u_cnt (.in(in), .out(cnt));

  assign accept = in_valid && in_ready;
  // A frame closes on in_last or when this beat fills the last slot.
  assign close  = accept && (in_last || (nslice == SW'(FRAME - 1)));

  always_ff @(posedge clk) begin
    if (reset) state <= CBA_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CBA_RUN:  if (close)     state_nxt = CBA_HOLD;
      CBA_HOLD: if (out_ready) state_nxt = CBA_RUN;
      default:                 state_nxt = CBA_RUN;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      CBA_RUN:  in_ready  = 1'b1;
      CBA_HOLD: out_valid = 1'b1;
      default:  ;
    endcase
  end

  // cnt never exceeds IN, so the CW cast is lossless even when CW < PW.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      nslice <= '0;
      ovf    <= 1'b0;
    end else if (state == CBA_RUN) begin
      if (accept) begin
        acc    <= acc + CW'(cnt);
        nslice <= nslice + SW'(1);
        if (close) ovf <= !in_last;
      end
    end else if (out_ready) begin
      acc    <= '0;
      nslice <= '0;
      ovf    <= 1'b0;
    end
  end

  assign out        = acc;
  assign out_nslice = nslice;
  assign out_ovf    = ovf;

endmodule

// File: tb/tb_cnt_bits_acc.sv
// Directed and randomized checks of cnt_bits_acc (IN=5, FRAME=4), with a
// second ACT=LOW instance sharing the same stimulus.
module tb_cnt_bits_acc;
  import parammod_pkg::*;

  localparam int IN = 5, FRAME = 4, SW = 3, CW = 5;

  logic          clk = 1'b0, reset = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [IN-1:0] in = '0;
  logic          in_ready, out_valid, out_ovf;
  logic [CW-1:0] out;
  logic [SW-1:0] out_nslice;
  logic          l_in_ready, l_out_valid, l_out_ovf;
  logic [CW-1:0] l_out;
  logic [SW-1:0] l_out_nslice;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cnt_bits_acc #(.IN(IN), .ACT(HIGH), .FRAME(FRAME)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_nslice(out_nslice), .out_ovf(out_ovf));

  cnt_bits_acc #(.IN(IN), .ACT(LOW), .FRAME(FRAME)) dut_low (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready), .in(in),
    .in_last(in_last), .out_valid(l_out_valid), .out_ready(out_ready), .out(l_out),
    .out_nslice(l_out_nslice), .out_ovf(l_out_ovf));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [IN-1:0] d, input logic last);
    in_valid = 1'b1; in = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out !== 5'd0)       begin errors++; $display("FAIL reset_out got %0d exp 0", out); end
    checks++; if (out_nslice !== 3'd0) begin errors++; $display("FAIL reset_nslice got %0d exp 0", out_nslice); end
    checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf got %b exp 0", out_ovf); end
  endtask

  task automatic test_frame();
    out_ready = 1'b1;
    send_beat(5'b10110, 1'b0);
    send_beat(5'b11111, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid got %b exp 0", out_valid); end
    send_beat(5'b00001, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b exp 1", out_valid); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL frame_in_ready got %b exp 0", in_ready); end
    checks++; if (out !== 5'd9)       begin errors++; $display("FAIL frame_out got %0d exp 9", out); end
    checks++; if (out_nslice !== 3'd3) begin errors++; $display("FAIL frame_nslice got %0d exp 3", out_nslice); end
    checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL frame_ovf got %b exp 0", out_ovf); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL frame_release got valid %b ready %b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_ovf();
    for (int i = 0; i < FRAME; i++) send_beat(5'b00011, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b exp 1", out_valid); end
    checks++; if (out !== 5'd8)       begin errors++; $display("FAIL ovf_out got %0d exp 8", out); end
    checks++; if (out_nslice !== 3'd4) begin errors++; $display("FAIL ovf_nslice got %0d exp 4", out_nslice); end
    checks++; if (out_ovf !== 1'b1)   begin errors++; $display("FAIL ovf_flag got %b exp 1", out_ovf); end
    tick();
    send_beat(5'b00011, 1'b1);
    checks++; if (out !== 5'd2 || out_nslice !== 3'd1 || out_ovf !== 1'b0)
      begin errors++; $display("FAIL ovf_next got out %0d ns %0d ovf %b exp 2 1 0", out, out_nslice, out_ovf); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_beat(5'b11000, 1'b0);
    send_beat(5'b00111, 1'b1);
    // Offer a beat while held; it must not be taken.
    in_valid = 1'b1; in = 5'b11111; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 5'd5 || out_nslice !== 3'd2)
        begin errors++; $display("FAIL hold_%0d got valid %b ready %b out %0d ns %0d exp 1 0 5 2", i, out_valid, in_ready, out, out_nslice); end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out !== 5'd0 || out_nslice !== 3'd0)
      begin errors++; $display("FAIL hold_clear got valid %b out %0d ns %0d exp 0 0 0", out_valid, out, out_nslice); end
  endtask

  task automatic test_single();
    do_reset();
    send_beat(5'b00000, 1'b1);
    checks++; if (out_valid !== 1'b1 || out !== 5'd0 || out_nslice !== 3'd1)
      begin errors++; $display("FAIL single_high got valid %b out %0d ns %0d exp 1 0 1", out_valid, out, out_nslice); end
    checks++; if (l_out_valid !== 1'b1 || l_out !== 5'd5 || l_out_nslice !== 3'd1)
      begin errors++; $display("FAIL single_low got valid %b out %0d ns %0d exp 1 5 1", l_out_valid, l_out, l_out_nslice); end
    tick();
  endtask

  task automatic test_reset_mid();
    send_beat(5'b11111, 1'b0);
    send_beat(5'b11111, 1'b0);
    do_reset();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 5'd0)
      begin errors++; $display("FAIL midrst got valid %b ready %b out %0d exp 0 1 0", out_valid, in_ready, out); end
    send_beat(5'b11111, 1'b1);
    checks++; if (out_valid !== 1'b1 || out !== 5'd5 || out_nslice !== 3'd1)
      begin errors++; $display("FAIL midrst_next got valid %b out %0d ns %0d exp 1 5 1", out_valid, out, out_nslice); end
    tick();
  endtask

  // Scoreboard: queue of accepted slices; each result pops one frame's worth.
  logic [IN-1:0] sq_data[$];
  logic          sq_last[$];

  task automatic test_random();
    int nframes = 1000, done = 0, mism = 0;
    bit prod_ok = 1;
    do_reset();
    fork
      begin : producer
        for (int f = 0; f < nframes && prod_ok; f++) begin
          int len = $urandom_range(1, FRAME);
          bit lastflag = (len < FRAME) ? 1'b1 : 1'($urandom_range(0, 1));
          for (int b = 0; b < len && prod_ok; b++) begin
            int w = 0;
            repeat ($urandom_range(0, 2)) tick();
            while (!in_ready && w < 200) begin tick(); w++; end
            if (!in_ready) begin prod_ok = 0; break; end
            in = IN'($urandom); in_last = (b == len - 1) && lastflag; in_valid = 1'b1;
            sq_data.push_back(in); sq_last.push_back(in_last);
            tick();
            in_valid = 1'b0; in_last = 1'b0;
          end
        end
      end
      begin : consumer
        int cyc = 0;
        bit seen = 0;
        while (done < nframes && cyc < 60000) begin
          if (out_valid && !seen) begin
            int ec = 0, en = 0; bit eo = 1, lst = 0;
            while (sq_data.size() > 0 && en < FRAME && !lst) begin
              logic [IN-1:0] d = sq_data.pop_front();
              lst = sq_last.pop_front();
              for (int k = 0; k < IN; k++) if (d[k] == HIGH) ec++;
              en++;
            end
            if (lst) eo = 0;
            seen = 1;
            checks++;
            if (en == 0 || out !== CW'(ec) || out_nslice !== SW'(en) || out_ovf !== eo) begin
              errors++; mism++;
              if (mism <= 10) $display("FAIL rand_frame_%0d got out %0d ns %0d ovf %b exp %0d %0d %b", done, out, out_nslice, out_ovf, ec, en, eo);
            end
          end
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin done++; seen = 0; end
          tick(); cyc++;
        end
      end
    join
    out_ready = 1'b1;
    checks++; if (done != nframes || !prod_ok) begin errors++; $display("FAIL rand_frames got %0d exp %0d", done, nframes); end
    checks++; if (sq_data.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d slices exp 0", sq_data.size()); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ovf();
    test_back_to_back();
    test_single();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_bits_acc.md
# cnt_bits_acc

Frame-level population counter that sits directly downstream of `cnt_bits`. It accepts a stream of `IN`-bit slices over a valid/ready handshake and counts the `ACT`-valued bits in each slice with an internal `cnt_bits` instance. It accumulates the per-slice counts across a frame terminated by `in_last`, then presents the frame total, the slice count and an overflow flag on a valid/ready output port.

## Interface

Parameters:
- `IN`, default 5: slice width in bits.
- `ACT`, default `` `HIGH ``: bit value that is counted; passed through to `cnt_bits`.
- `FRAME`, default 4: maximum slices per frame.
- `SW`, default `$clog2(FRAME+1)`: slice-counter width (derived; do not override).
- `CW`, default `$clog2(IN*FRAME+1)`: total-count width (derived; do not override).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  slice present on `in`.
- `in_ready`  out  1  block accepts a slice this cycle.
- `in`  in  IN  slice data.
- `in_last`  in  1  this slice ends the frame; qualified by `in_valid`.
- `out_valid`  out  1  frame result held on the outputs.
- `out_ready`  in  1  consumer takes the result.
- `out`  out  CW  number of `ACT` bits in the frame.
- `out_nslice`  out  SW  slices accepted in the frame, 1..FRAME.
- `out_ovf`  out  1  frame was force-closed at FRAME slices with no `in_last`.

## Operation

- Beat accepted when `in_valid && in_ready`.
- Two-state FSM:
  - RUN: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- In RUN, each accepted beat does the following:
  - `acc <= acc + cnt_bits(in)`, where the `cnt_bits` output is zero-extended to CW.
  - `nslice <= nslice + 1`.
- RUN -> HOLD happens on an accepted beat that meets either condition:
  - `in_last`=1, which sets `ovf`=0.
  - `nslice == FRAME-1` with `in_last`=0, which sets `ovf`=1. The frame is force-closed and the next accepted beat starts a new frame.
- The HOLD-entry beat's contribution is included in the registered `out` and `out_nslice`.
- HOLD -> RUN on `out_ready`=1. In the same edge, `acc`, `nslice` and `ovf` are cleared.
- In HOLD, `out`, `out_nslice` and `out_ovf` are stable, and `out_valid` stays high until `out_ready`.
- `in` and `in_last` are ignored when `in_valid`=0.
- `out_ready` is ignored in RUN.
- Arithmetic: `acc` cannot exceed `IN*FRAME`, so there is no wrap. `nslice` never exceeds FRAME.

## Timing

- Reset (synchronous, dominates all other inputs):
  - state = RUN
  - `acc`, `nslice`, `ovf` = 0
  - `in_ready` = 1, `out_valid` = 0, `out` = 0, `out_nslice` = 0, `out_ovf` = 0
- Reset asserted mid-frame or in HOLD discards the partial frame or pending result. There is no output for that frame.
- Latency: `out_valid` rises in the cycle after the closing beat is accepted.
- Throughput: an N-slice frame occupies N+1 cycles minimum, because the HOLD cycle accepts no input. Back-pressure extends HOLD.
- `in_ready` is a pure function of state, with no combinational path from `in_valid`.
- `out_valid` is a pure function of state, with no combinational path from `out_ready`.
- A one-slice frame (`in_last` on the first beat) is legal: `out_nslice`=1.
- An all-zero frame gives `out`=0 with `out_valid` still asserted.
- With FRAME=1 every beat closes a frame. `out_ovf`=1 iff `in_last`=0.

## Structure

- The shared package (`parammod_pkg`) holds:
  - the FSM state typedef `cba_state_t` = {CBA_RUN, CBA_HOLD};
  - `HIGH`/`LOW` from the existing stddef header.
- One sub-module: `cnt_bits #(.IN(IN), .ACT(ACT))`, instantiated combinationally on `in`. Its output width is `$clog2(IN)+1`.
- Expected RTL is about 150 lines: FSM, accumulator and slice counter, output registers driven directly from `acc`, `nslice` and `ovf`.

## Test plan

All scenarios use IN=5, ACT=HIGH, FRAME=4, `out_ready`=1 unless stated.

1. Reset, then slices 5'b10110, 5'b11111, 5'b00001 with `in_last` on the third -> one cycle later `out_valid`=1, `out`=9, `out_nslice`=3, `out_ovf`=0. In that cycle `in_ready`=0.
2. Four slices 5'b00011 with no `in_last` -> `out`=8, `out_nslice`=4, `out_ovf`=1. A fifth slice starts a new frame with `acc` counting from 0.
3. With `out_ready`=0 for 5 cycles after a frame closes -> `out_valid`, `out` and `out_nslice` are held constant and `in_ready`=0 throughout. The result clears on the first `out_ready`=1 cycle.
4. Single slice 5'b00000 with `in_last` -> `out`=0, `out_nslice`=1, `out_valid`=1. Repeat with ACT=LOW -> `out`=5.
5. Assert `reset` for one cycle after two beats of a frame -> no `out_valid` for that frame. A following 1-slice frame 5'b11111 gives `out`=5, `out_nslice`=1.
6. Random `in_valid`/`out_ready` gaps over 1000 frames against a scoreboard that pops IN-bit slices and counts ACT bits -> every result matches, and no beat is lost or duplicated.
